multi_channel_frequency_meter: RTL and testbench

- Multi-channel frequency/period meter for the vf_meter designs. Successor to the single-channel gated edge counter.
- All channels share one gate timebase. Each channel has its own measurement mode.
- External inputs are synchronised into the single `clk` domain. There is no second clock domain and no stop/reset handshake.
- Results are latched at each gate end, read through a channel-select mux, and announced by one interrupt.

---
 rtl/multi_channel_frequency_meter.sv | 186 ++++++++++++++++++
 tb/tb_multi_channel_frequency_meter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_frequency_meter.sv
`timescale 1ns/1ps
// Multi-channel gated frequency/period meter sharing one gate timebase; results latch at gate end.
// Latency: input edge reaches counters SYNC_STAGES+1 clk after iclk; results/interrupt 1 clk after gate end; no backpressure.
module multi_channel_frequency_meter #(
  parameter int CHANNELS          = 4,
  parameter int CLK_COUNTER_WIDTH = 28,
  parameter int COUNTER_WIDTH     = 28,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                                               clk,
  input  logic                                               nreset,
  input  logic [CHANNELS-1:0]                                iclk,
  input  logic [CLK_COUNTER_WIDTH-3:0]                       clk_frequency_div4,
  input  logic [CHANNELS-1:0]                                mode,
  input  logic                                               enable,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] channel_sel,
  output logic [COUNTER_WIDTH-1:0]                           code,
  output logic                                               overflow,
  output logic                                               valid,
  output logic                                               interrupt,
  input  logic                                               interrupt_clear
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] edge_det;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= iclk;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  logic [CLK_COUNTER_WIDTH-1:0] gate_cnt_q;
  logic [CLK_COUNTER_WIDTH-1:0] gate_last_q;
  logic [CHANNELS-1:0]          mode_sh_q;
  logic [CHANNELS-1:0]          mode_eff;
  logic                         gate_start;
  logic                         gate_end;

  // gate_last_q is stale during the start cycle, hence the !gate_start guard (G >= 4)
  assign gate_start = enable && (gate_cnt_q == '0);
  assign gate_end   = enable && !gate_start && (gate_cnt_q == gate_last_q);
  assign mode_eff   = gate_start ? mode : mode_sh_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gate_cnt_q  <= '0;
      gate_last_q <= '0;
      mode_sh_q   <= '0;
    end else begin
      if (!enable || gate_end) gate_cnt_q <= '0;
      else                     gate_cnt_q <= gate_cnt_q + 1'b1;
      if (gate_start) begin
        gate_last_q <= {clk_frequency_div4, 2'b11};
        mode_sh_q   <= mode;
      end
    end
  end

  logic [COUNTER_WIDTH-1:0] cnt_q    [CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt_d    [CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt_inc  [CHANNELS];
  logic [COUNTER_WIDTH-1:0] last_q   [CHANNELS];
  logic [COUNTER_WIDTH-1:0] last_d   [CHANNELS];
  logic [COUNTER_WIDTH-1:0] lat_code [CHANNELS];
  logic [COUNTER_WIDTH-1:0] code_q   [CHANNELS];
  logic [CHANNELS-1:0] cnt_sat;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] armed_q, armed_d;
  logic [CHANNELS-1:0] have_q, have_d;
  logic [CHANNELS-1:0] lovf_q, lovf_d;
  logic [CHANNELS-1:0] lat_ovf, lat_vld;
  logic [CHANNELS-1:0] ovf_lat_q, vld_lat_q;

  always_comb begin
    cnt_sat = '0;
    ovf_d   = ovf_q;
    armed_d = armed_q;
    have_d  = have_q;
    lovf_d  = lovf_q;
    lat_ovf = '0;
    lat_vld = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_sat[i]  = (cnt_q[i] == CNT_MAX);
      cnt_inc[i]  = cnt_sat[i] ? CNT_MAX : cnt_q[i] + 1'b1;
      cnt_d[i]    = cnt_q[i];
      last_d[i]   = last_q[i];
      lat_code[i] = '0;
      if (mode_eff[i]) begin
        // period: first edge arms, each later edge closes one period of cnt+1 clocks
        if (edge_det[i]) begin
          if (armed_q[i]) begin
            have_d[i] = 1'b1;
            last_d[i] = cnt_inc[i];
            lovf_d[i] = ovf_q[i] | cnt_sat[i];
          end
          armed_d[i] = 1'b1;
          cnt_d[i]   = '0;
          ovf_d[i]   = 1'b0;
        end else if (armed_q[i]) begin
          cnt_d[i] = cnt_inc[i];
          ovf_d[i] = ovf_q[i] | cnt_sat[i];
        end
        lat_code[i] = have_d[i] ? last_d[i] : CNT_MAX;
        lat_ovf[i]  = have_d[i] ? lovf_d[i] : 1'b1;
        lat_vld[i]  = have_d[i];
      end else begin
        if (edge_det[i]) begin
          cnt_d[i] = cnt_inc[i];
          ovf_d[i] = ovf_q[i] | cnt_sat[i];
        end
        lat_code[i] = cnt_d[i];
        lat_ovf[i]  = ovf_d[i];
        lat_vld[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        last_q[i] <= '0;
        code_q[i] <= '0;
      end
      ovf_q     <= '0;
      armed_q   <= '0;
      have_q    <= '0;
      lovf_q    <= '0;
      ovf_lat_q <= '0;
      vld_lat_q <= '0;
    end else begin
      if (!enable || gate_end) begin
        for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        ovf_q   <= '0;
        armed_q <= '0;
        have_q  <= '0;
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          cnt_q[i]  <= cnt_d[i];
          last_q[i] <= last_d[i];
        end
        ovf_q   <= ovf_d;
        armed_q <= armed_d;
        have_q  <= have_d;
        lovf_q  <= lovf_d;
      end
      if (gate_end) begin
        for (int i = 0; i < CHANNELS; i++) code_q[i] <= lat_code[i];
        ovf_lat_q <= lat_ovf;
        vld_lat_q <= lat_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)              interrupt <= 1'b0;
    else if (gate_end)        interrupt <= 1'b1;
    else if (interrupt_clear) interrupt <= 1'b0;
  end

  always_comb begin
    code     = '0;
    overflow = 1'b0;
    valid    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (channel_sel == SEL_W'(i)) begin
        code     = code_q[i];
        overflow = ovf_lat_q[i];
        valid    = vld_lat_q[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_frequency_meter.sv
`timescale 1ns/1ps
// Directed bench: a 4-channel default meter plus a 1-channel, 4-bit meter for saturation and out-of-range readout.
module tb_multi_channel_frequency_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic [4:0]  gen;
  int          hp [5];
  int          ph [5];

  logic [3:0]  iclk;
  logic [25:0] div4;
  logic [3:0]  mode;
  logic        enable;
  logic [1:0]  channel_sel;
  logic [27:0] code;
  logic        overflow, valid, interrupt, interrupt_clear;

  logic        iclk4, mode4, enable4, channel_sel4, clear4;
  logic [25:0] div4_4;
  logic [3:0]  code4;
  logic        ovf4, vld4, irq4;

  assign iclk  = gen[3:0];
  assign iclk4 = gen[4];

  multi_channel_frequency_meter dut (
    .clk(clk), .nreset(nreset), .iclk(iclk), .clk_frequency_div4(div4), .mode(mode),
    .enable(enable), .channel_sel(channel_sel), .code(code), .overflow(overflow),
    .valid(valid), .interrupt(interrupt), .interrupt_clear(interrupt_clear)
  );

  multi_channel_frequency_meter #(.CHANNELS(1), .COUNTER_WIDTH(4)) dut4 (
    .clk(clk), .nreset(nreset), .iclk(iclk4), .clk_frequency_div4(div4_4), .mode(mode4),
    .enable(enable4), .channel_sel(channel_sel4), .code(code4), .overflow(ovf4),
    .valid(vld4), .interrupt(irq4), .interrupt_clear(clear4)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // square-wave sources toggling on the falling clock edge; hp = half period in clk cycles, 0 = tied low
  initial begin
    gen = '0;
    for (int i = 0; i < 5; i++) ph[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (hp[i] == 0) begin
          gen[i] = 1'b0;
          ph[i]  = 0;
        end else begin
          ph[i]++;
          if (ph[i] >= hp[i]) begin
            ph[i]  = 0;
            gen[i] = ~gen[i];
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic gate(input bit which, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (((which ? irq4 : interrupt) !== 1'b1) && waited < 1000);
    chk(which ? "irq4_seen" : "irq_seen", 32'(which ? irq4 : interrupt), 1);
  endtask

  task automatic clr(input bit which);
    if (which) clear4 = 1'b1;
    else       interrupt_clear = 1'b1;
    @(negedge clk);
    clear4          = 1'b0;
    interrupt_clear = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  mode;
    logic [1:0]  sel;
    logic [27:0] code;
    logic        ovf;
    logic        vld;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int w;
    int t_last;
    int hi;
    logic [3:0] cur_mode;

    // ch0,ch1: period 10; ch2: tied low; ch3: period 2; G = 100
    tbl[0] = '{4'b1010, 2'd0, 28'd10,        1'b0, 1'b1};
    tbl[1] = '{4'b1010, 2'd1, 28'd10,        1'b0, 1'b1};
    tbl[2] = '{4'b1010, 2'd2, 28'd0,         1'b0, 1'b1};
    tbl[3] = '{4'b1010, 2'd3, 28'd2,         1'b0, 1'b1};
    tbl[4] = '{4'b0101, 2'd0, 28'd10,        1'b0, 1'b1};
    tbl[5] = '{4'b0101, 2'd1, 28'd10,        1'b0, 1'b1};
    tbl[6] = '{4'b0101, 2'd2, 28'hFFFFFFF,   1'b1, 1'b0};
    tbl[7] = '{4'b0101, 2'd3, 28'd50,        1'b0, 1'b1};

    nreset = 1'b0; enable = 1'b1; mode = 4'b1010; channel_sel = 2'd0;
    div4 = 26'd24; interrupt_clear = 1'b0;
    enable4 = 1'b1; mode4 = 1'b0; channel_sel4 = 1'b0; div4_4 = 26'd24; clear4 = 1'b0;
    hp = '{5, 5, 0, 1, 1};
    t_last = 0;
    cur_mode = 4'hF;

    repeat (3) @(negedge clk);
    chk("rst_code", 32'(code), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_interrupt", 32'(interrupt), 0);
    chk("rst_code4", 32'(code4), 0);
    nreset = 1'b1;

    for (int k = 0; k < 8; k++) begin
      if (tbl[k].mode != cur_mode) begin
        cur_mode = tbl[k].mode;
        mode = cur_mode;
        gate(0, w); clr(0);
        gate(0, w); t_last = cyc; clr(0);
      end
      gate(0, w);
      chk($sformatf("tbl%0d_interval", k), 32'(cyc - t_last), 100);
      t_last = cyc;
      channel_sel = tbl[k].sel;
      #1;
      chk($sformatf("tbl%0d_code", k), 32'(code), 32'(tbl[k].code));
      chk($sformatf("tbl%0d_overflow", k), 32'(overflow), 32'(tbl[k].ovf));
      chk($sformatf("tbl%0d_valid", k), 32'(valid), 32'(tbl[k].vld));
      clr(0);
    end
    channel_sel = 2'd0;

    // clear coincident with the set edge loses; clear one cycle later wins
    gate(0, w);
    interrupt_clear = 1'b1;
    @(negedge clk);
    interrupt_clear = 1'b0;
    repeat (98) @(negedge clk);
    interrupt_clear = 1'b1;
    @(negedge clk);
    chk("irq_set_wins", 32'(interrupt), 1);
    @(negedge clk);
    chk("irq_clear_next", 32'(interrupt), 0);
    interrupt_clear = 1'b0;

    // mid-gate mode and gate-length change at gate_cnt = 50
    mode = 4'b1010;
    gate(0, w); clr(0);
    gate(0, w); clr(0);
    gate(0, w); t_last = cyc; clr(0);
    repeat (49) @(negedge clk);
    mode = 4'b0011;
    div4 = 26'd49;
    gate(0, w);
    chk("mid_interval_old", 32'(cyc - t_last), 100);
    t_last = cyc;
    channel_sel = 2'd3; #1;
    chk("mid_old_ch3_code", 32'(code), 2);
    channel_sel = 2'd0; #1;
    chk("mid_old_ch0_code", 32'(code), 10);
    clr(0);
    gate(0, w);
    chk("mid_interval_new", 32'(cyc - t_last), 200);
    channel_sel = 2'd3; #1;
    chk("mid_new_ch3_code", 32'(code), 100);
    chk("mid_new_ch3_valid", 32'(valid), 1);
    channel_sel = 2'd0; #1;
    chk("mid_new_ch0_code", 32'(code), 10);
    chk("mid_new_ch0_valid", 32'(valid), 1);
    div4 = 26'd24;
    mode = 4'b1010;
    clr(0);
    gate(0, w); clr(0);
    gate(0, w); clr(0);

    // drop enable mid-gate with clear held: no interrupt, latched results hold
    gate(0, w); clr(0);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    interrupt_clear = 1'b1;
    hi = 0;
    repeat (250) begin
      @(negedge clk);
      if (interrupt) hi++;
    end
    interrupt_clear = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (interrupt) hi++;
    end
    chk("dis_irq_high_cycles", 32'(hi), 0);
    channel_sel = 2'd0; #1;
    chk("dis_hold_ch0_code", 32'(code), 10);
    chk("dis_hold_ch0_valid", 32'(valid), 1);
    channel_sel = 2'd3; #1;
    chk("dis_hold_ch3_code", 32'(code), 2);
    channel_sel = 2'd0;
    @(negedge clk);
    enable = 1'b1;
    gate(0, w);
    chk("en_first_gate_cycles", 32'(w), 100);
    clr(0);

    // asynchronous reset at gate_cnt = 60
    gate(0, w); clr(0);
    repeat (59) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("arst_code", 32'(code), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_interrupt", 32'(interrupt), 0);
    channel_sel = 2'd3; #1;
    chk("arst_ch3_code", 32'(code), 0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    channel_sel = 2'd0;
    gate(0, w);
    chk("arst_first_gate_cycles", 32'(w), 100);
    chk("arst_first_gate_valid", 32'(valid), 1);
    clr(0);

    // 4-bit counter saturation, out-of-range select, recovery
    clr(1);
    gate(1, w); clr(1);
    gate(1, w);
    chk("ovf4_code", 32'(code4), 15);
    chk("ovf4_overflow", 32'(ovf4), 1);
    chk("ovf4_valid", 32'(vld4), 1);
    channel_sel4 = 1'b1; #1;
    chk("sel_oor_code", 32'(code4), 0);
    chk("sel_oor_overflow", 32'(ovf4), 0);
    chk("sel_oor_valid", 32'(vld4), 0);
    channel_sel4 = 1'b0;
    hp[4] = 10;
    clr(1);
    gate(1, w); clr(1);
    gate(1, w);
    chk("rec4_code", 32'(code4), 5);
    chk("rec4_overflow", 32'(ovf4), 0);
    chk("rec4_valid", 32'(vld4), 1);
    clr(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
